// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the four-way round-robin select arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage : mux_arb_pkg

// File: rtl/rr_pick.sv
// Rotated-priority search: first set request starting just after ptr, wrapping to ptr itself.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the lowest-priority slot (ptr) up to the highest (ptr+1) so the
  // last hit, which is the nearest one after ptr, wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a 4:1 select path with a bounded hold time and a registered data output.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] i,
  output logic [SEL_W-1:0] s,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             y
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [7:0]       hold_cnt;
  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;
  logic             release_now;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Owner dropping its request and hitting the hold limit collapse into one release.
  assign release_now = !req[s] || (hold_cnt == 8'(MAX_HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: only control/output flops here, so all of them are reset; ptr=3 makes index 0 search first.
    if (!rst_n) begin
      state    <= IDLE;
      s        <= '0;
      gnt      <= '0;
      busy     <= 1'b0;
      y        <= 1'b0;
      ptr      <= SEL_W'(N_REQ - 1);
      hold_cnt <= '0;
    end else begin
      // NOTE: non-blocking so y sees the pre-edge busy and s, giving its one-cycle lag.
      y <= busy ? i[s] : 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= GRANT;
            s        <= pick_idx;
            gnt      <= N_REQ'(1) << pick_idx;
            busy     <= 1'b1;
            hold_cnt <= 8'd1;
          end
        end
        GRANT: begin
          if (release_now) begin
            state    <= IDLE;
            ptr      <= s;
            gnt      <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : mux4_rr_arbiter
